// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: drives a word-organised data memory through a
// req/ready handshake, aligns store lanes, extends load data and stalls the pipeline.
module mem_access_unit #(
    parameter int data_bits = 32
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 mem_read_in,
    input  logic                 mem_write_in,
    input  logic [2:0]           funct3_in,
    input  logic [data_bits-1:0] address_in,
    input  logic [data_bits-1:0] store_data_in,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [data_bits-1:0] dmem_addr,
    output logic [3:0]           dmem_be,
    output logic [data_bits-1:0] dmem_wdata,
    input  logic [data_bits-1:0] dmem_rdata,
    input  logic                 dmem_ready,
    output logic                 stall_out,
    output logic [data_bits-1:0] load_data_out,
    output logic                 load_valid_out,
    output logic                 error_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        is_load_s;
    logic        size_ok_s;
    logic        align_ok_s;
    logic        err_s;
    logic        access_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic [2:0]  funct3_r;
    logic [1:0]  k_r;
    logic        is_load_r;

    // Selects the addressed byte/half lane of a read word and sign- or zero-extends it.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  k);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{k, 3'b000} +: 8];
        h = k[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Legality of the requested access; a store takes precedence over a load.
    always_comb begin
        is_load_s  = mem_read_in & ~mem_write_in;
        size_ok_s  = 1'b0;
        align_ok_s = 1'b1;
        case (funct3_in)
            3'b000, 3'b001, 3'b010: size_ok_s = 1'b1;
            3'b100, 3'b101:         size_ok_s = is_load_s;
            default:                size_ok_s = 1'b0;
        endcase
        case (funct3_in[1:0])
            2'b01:   align_ok_s = ~address_in[0];
            2'b10:   align_ok_s = (address_in[1:0] == 2'b00);
            default: align_ok_s = 1'b1;
        endcase
        if (mem_read_in | mem_write_in) begin
            err_s = ~(size_ok_s & align_ok_s);
        end else begin
            err_s = 1'b0;
        end
        access_s = (mem_read_in | mem_write_in) & ~err_s;
    end

    // Byte-enable and replicated write data for the addressed lane.
    always_comb begin
        be_s    = 4'b1111;
        wdata_s = store_data_in;
        case (funct3_in[1:0])
            2'b00: begin
                be_s    = 4'b0001 << address_in[1:0];
                wdata_s = {4{store_data_in[7:0]}};
            end
            2'b01: begin
                be_s    = address_in[1] ? 4'b1100 : 4'b0011;
                wdata_s = {2{store_data_in[15:0]}};
            end
            default: begin
                be_s    = 4'b1111;
                wdata_s = store_data_in;
            end
        endcase
    end

    // Stall is forced low while reset is asserted so an abandoned access releases the pipeline.
    always_comb begin
        if (!n_reset) begin
            stall_out = 1'b0;
        end else if (state_r == BUSY) begin
            stall_out = 1'b1;
        end else if (state_r == IDLE) begin
            stall_out = access_s;
        end else begin
            stall_out = 1'b0;
        end
    end

    assign error_out = err_s;

    // State register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; DONE never samples the inputs, so the same instruction cannot re-trigger.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (access_s) begin
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (dmem_ready) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Registered memory request, load result and valid pulse.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_be        <= 4'b0000;
            dmem_wdata     <= '0;
            load_data_out  <= '0;
            load_valid_out <= 1'b0;
            funct3_r       <= 3'b000;
            k_r            <= 2'b00;
            is_load_r      <= 1'b0;
        end else begin
            load_valid_out <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (access_s) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_write_in;
                        dmem_addr  <= {address_in[data_bits-1:2], 2'b00};
                        dmem_be    <= be_s;
                        dmem_wdata <= wdata_s;
                        funct3_r   <= funct3_in;
                        k_r        <= address_in[1:0];
                        is_load_r  <= is_load_s;
                    end
                end
                BUSY: begin
                    if (dmem_ready) begin
                        dmem_req <= 1'b0;
                        if (is_load_r) begin
                            load_data_out  <= extend_load(dmem_rdata, funct3_r, k_r);
                            load_valid_out <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized bench for mem_access_unit against an arithmetic model of the access rules.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        mem_read_in = 1'b0;
    logic        mem_write_in = 1'b0;
    logic [2:0]  funct3_in = 3'b000;
    logic [31:0] address_in = 32'd0;
    logic [31:0] store_data_in = 32'd0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = 32'd0;
    logic        dmem_ready = 1'b0;
    logic        stall_out;
    logic [31:0] load_data_out;
    logic        load_valid_out;
    logic        error_out;

    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    logic [31:0] held = 32'd0;

    mem_access_unit #(.data_bits(32)) dut (
        .clk(clk), .n_reset(n_reset),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .funct3_in(funct3_in), .address_in(address_in), .store_data_in(store_data_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .stall_out(stall_out), .load_data_out(load_data_out),
        .load_valid_out(load_valid_out), .error_out(error_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: legality, lanes and load extension computed arithmetically from access size.
    function automatic void model(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] sdata,
                                  input logic [31:0] rdata, output logic err,
                                  output logic [3:0] be, output logic [31:0] wd,
                                  output logic [31:0] ld);
        int     bytes;
        int     off;
        logic   legal;
        longint v;
        longint span;
        longint mask;
        bytes = 1 << f3[1:0];
        off   = int'(addr % 32'd4);
        if (wr) legal = (f3 <= 3'd2);
        else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        err   = (rd || wr) && (!legal || (off % bytes) != 0);
        mask  = (longint'(1) << bytes) - 1;
        be    = 4'(mask << off);
        if (bytes == 1)      wd = 32'(sdata[7:0]) * 32'h01010101;
        else if (bytes == 2) wd = 32'(sdata[15:0]) * 32'h00010001;
        else                 wd = sdata;
        span = longint'(1) << (8 * bytes);
        v    = (longint'(rdata) >> (8 * off)) & (span - 1);
        if (f3[2] == 1'b0 && bytes < 4 && v >= span / 2) v = v - span;
        ld = v[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction in an IDLE cycle and follows it to completion.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] sdata,
                             input logic [31:0] rdata, input int waits);
        logic        e;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] ld;
        model(rd, wr, f3, addr, sdata, rdata, e, be, wd, ld);
        mem_read_in   = rd;
        mem_write_in  = wr;
        funct3_in     = f3;
        address_in    = addr;
        store_data_in = sdata;
        dmem_ready    = e || !(rd || wr);
        dmem_rdata    = $urandom;
        @(negedge clk);
        check("error", 32'(error_out), 32'(e));
        check("detect_stall", 32'(stall_out), 32'((rd || wr) && !e));
        check("detect_req", 32'(dmem_req), 32'd0);
        if (e || !(rd || wr)) begin
            tick();
            check("no_req", 32'(dmem_req), 32'd0);
            check("no_ldv", 32'(load_valid_out), 32'd0);
            check("hold_data", load_data_out, held);
            mem_read_in  = 1'b0;
            mem_write_in = 1'b0;
            dmem_ready   = 1'b0;
            return;
        end
        tick();
        for (int i = 0; i <= waits; i++) begin
            dmem_ready = (i == waits);
            dmem_rdata = (i == waits) ? rdata : $urandom;
            @(negedge clk);
            check("busy_req", 32'(dmem_req), 32'd1);
            check("busy_we", 32'(dmem_we), 32'(wr));
            check("busy_addr", dmem_addr, {addr[31:2], 2'b00});
            check("busy_be", 32'(dmem_be), 32'(be));
            check("busy_wdata", dmem_wdata, wd);
            check("busy_stall", 32'(stall_out), 32'd1);
            tick();
        end
        dmem_ready = 1'b0;
        dmem_rdata = $urandom;
        @(negedge clk);
        if (rd && !wr) held = ld;
        check("done_stall", 32'(stall_out), 32'd0);
        check("done_req", 32'(dmem_req), 32'd0);
        check("done_ldv", 32'(load_valid_out), 32'(rd && !wr));
        check("done_data", load_data_out, held);
        tick();
        check("no_retrigger", 32'(dmem_req), 32'd0);
        check("idle_ldv", 32'(load_valid_out), 32'd0);
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
    endtask

    initial begin
        #2;
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_we", 32'(dmem_we), 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_be", 32'(dmem_be), 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_ldata", load_data_out, 32'd0);
        check("rst_ldv", 32'(load_valid_out), 32'd0);
        check("rst_stall", 32'(stall_out), 32'd0);
        tick();
        n_reset = 1'b1;

        do_access(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0, 32'hDEADBEEF, 0);
        do_access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF7F01, 0);
        check("lb_value", load_data_out, 32'hFFFFFF80);
        do_access(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'd0, 32'h80FF7F01, 1);
        check("lbu_value", load_data_out, 32'h00000080);
        do_access(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234ABCD, 32'd0, 3);
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'd0, 32'd0, 0);
        do_access(1'b0, 1'b1, 3'b001, 32'h0000_0001, 32'h5555AAAA, 32'd0, 0);
        do_access(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'd0, 32'd0, 0);
        do_access(1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'd0, 32'd0, 0);

        mem_read_in = 1'b1;
        funct3_in   = 3'b010;
        address_in  = 32'h0000_0300;
        dmem_ready  = 1'b0;
        tick();
        @(negedge clk);
        check("pre_rst_req", 32'(dmem_req), 32'd1);
        #1 n_reset = 1'b0;
        #1;
        check("mid_rst_req", 32'(dmem_req), 32'd0);
        check("mid_rst_stall", 32'(stall_out), 32'd0);
        check("mid_rst_ldv", 32'(load_valid_out), 32'd0);
        dmem_ready = 1'b1;
        tick();
        mem_read_in = 1'b0;
        dmem_ready  = 1'b0;
        n_reset     = 1'b1;
        held        = 32'd0;
        @(negedge clk);
        check("post_rst_ldv", 32'(load_valid_out), 32'd0);
        check("post_rst_ldata", load_data_out, 32'd0);
        tick();
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'd0, 32'hCAFEF00D, 0);

        do_access(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'd0, 32'h01234567, 0);
        do_access(1'b0, 1'b1, 3'b010, 32'h0000_0504, 32'h89ABCDEF, 32'd0, 0);

        for (int n = 0; n < 60; n++) begin
            int          op;
            logic [31:0] a;
            op = $urandom_range(0, 3);
            a  = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            do_access(op == 1 || op == 3, op >= 2, 3'($urandom_range(0, 7)), a,
                      $urandom, $urandom, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
